// File: rtl/switch_debounce_pkg.sv
// Shared defaults for the slide-switch conditioner, plus the sizing helper
// for the per-bit stability counter.
package switch_debounce_pkg;

    localparam int SW_WIDTH        = 10;
    localparam int SW_TICK_DIV     = 50000;
    localparam int SW_STABLE_TICKS = 20;

    // The counter holds at most stable_ticks-1, so clog2(stable_ticks+1) bits suffice.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: stability counter, debounced output flop and change strobe.
// changed_next is exported so the top can register an aligned OR of all strobes.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic sync_bit,
    input  logic tick,
    output logic debounced,
    output logic changed,
    output logic changed_next
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          debounced_next;

    // Agreement with the output wipes progress even on a tick, so bounce restarts qualification.
    always_comb begin
        cnt_next       = cnt;
        debounced_next = debounced;
        changed_next   = 1'b0;
        if (sync_bit == debounced) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt == CNT_LAST) begin
                debounced_next = ~debounced;
                changed_next   = 1'b1;
                cnt_next       = '0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cnt       <= '0;
            debounced <= 1'b0;
            changed   <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            debounced <= debounced_next;
            changed   <= changed_next;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounces the raw slide-switch pins feeding the switches PIO: 2-flop
// synchroniser, shared sample-tick prescaler and one stability counter per bit.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = SW_TICK_DIV,
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sw_any_change,
    output logic             tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] changed_next;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // tick is registered off the terminal count, so it lands one edge after the wrap value.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (presc == PRESC_LAST);
            if (presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk_clk      (clk_clk),
            .reset_reset  (reset_reset),
            .sync_bit     (sync2[g]),
            .tick         (tick),
            .debounced    (sw_debounced[g]),
            .changed      (sw_changed[g]),
            .changed_next (changed_next[g])
        );
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sw_any_change <= 1'b0;
        end else begin
            sw_any_change <= |changed_next;
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed plus random stimulus for switch_debounce, checked every cycle
// against a behavioural model and with explicit latency/strobe checks.
module tb_switch_debounce;

    localparam int W    = 10;
    localparam int TDIV = 4;
    localparam int STB  = 3;
    localparam int LAT_MIN = 2 + (STB - 1) * TDIV + 1;
    localparam int LAT_MAX = 2 + STB * TDIV + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_debounced;
    logic [W-1:0] sw_changed;
    logic         sw_any_change;
    logic         tick;

    int errors = 0;
    int checks = 0;
    int strobes [W];

    switch_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (TDIV),
        .STABLE_TICKS (STB)
    ) dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .sw_raw        (sw_raw),
        .sw_debounced  (sw_debounced),
        .sw_changed    (sw_changed),
        .sw_any_change (sw_any_change),
        .tick          (tick)
    );

    always #5 clk = ~clk;

    // Reference model: raw input delayed two edges, tick every TDIV-th edge since
    // reset, and an integer run-length of ticks spent disagreeing with the output.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_chg = '0;
    logic [W-1:0] nd, nc;
    int           m_run [W];
    int           m_edges = 0;
    bit           m_tick = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_chg = '0;
            m_edges = 0; m_tick = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            nd = m_deb;
            nc = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] == m_deb[i]) begin
                    m_run[i] = 0;
                end else if (m_tick) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == STB) begin
                        nd[i] = ~m_deb[i];
                        nc[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
            m_edges = m_edges + 1;
            m_tick = (m_edges % TDIV) == 0;
            m_deb = nd;
            m_chg = nc;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat);
        checks++;
        assert (lat >= LAT_MIN && lat <= LAT_MAX) else begin
            errors++;
            $error("FAIL %s: observed latency=%0d expected %0d..%0d", tag, lat, LAT_MIN, LAT_MAX);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("deb", sw_debounced, m_deb);
        chk("chg", sw_changed, m_chg);
        chk("any", W'(sw_any_change), W'(|m_chg));
        chk("tick", W'(tick), W'(m_tick));
        for (int i = 0; i < W; i++) if (sw_changed[i]) strobes[i]++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_strobes();
        for (int i = 0; i < W; i++) strobes[i] = 0;
    endtask

    // Counts sample points until the masked output reaches val; -1 if it never does.
    task automatic wait_deb(input logic [W-1:0] mask, input logic [W-1:0] val,
                            output int lat, output logic [W-1:0] chg_at, output logic any_at);
        lat = -1;
        chg_at = '0;
        any_at = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if ((sw_debounced & mask) == (val & mask)) begin
                lat = k;
                chg_at = sw_changed;
                any_at = sw_any_change;
                break;
            end
        end
    endtask

    int           lat;
    logic [W-1:0] chg_at;
    logic         any_at;

    initial begin
        clear_strobes();

        // Reset held with every switch high.
        sw_raw = 10'h3FF;
        steps(3);
        chk("rst_deb", sw_debounced, 10'h000);
        chk("rst_chg", sw_changed, 10'h000);
        rst = 1'b0;
        wait_deb(10'h3FF, 10'h3FF, lat, chg_at, any_at);
        chk_lat("rst_release_lat", lat);
        chk("rst_release_chg", chg_at, 10'h3FF);
        chk("rst_release_any", W'(any_at), 10'h001);
        step();
        chk("rst_release_pulse_end", sw_changed, 10'h000);

        sw_raw = 10'h000;
        steps(20);
        chk("all_low", sw_debounced, 10'h000);

        // Clean step on bit 0.
        clear_strobes();
        sw_raw[0] = 1'b1;
        wait_deb(10'h001, 10'h001, lat, chg_at, any_at);
        chk_lat("step_lat", lat);
        chk("step_chg", chg_at, 10'h001);
        chk("step_others", sw_debounced, 10'h001);
        steps(5);
        chk("step_strobes", W'(strobes[0]), 10'd1);

        // Bounce on bit 3, then a final rising edge.
        clear_strobes();
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) sw_raw[3] = ~sw_raw[3];
            step();
        end
        chk("bounce_hold", sw_debounced, 10'h001);
        sw_raw[3] = 1'b1;
        wait_deb(10'h008, 10'h008, lat, chg_at, any_at);
        chk_lat("bounce_lat", lat);
        steps(5);
        chk("bounce_strobes", W'(strobes[3]), 10'd1);

        // Short glitch on bit 5.
        clear_strobes();
        sw_raw[5] = 1'b1;
        steps(3);
        sw_raw[5] = 1'b0;
        steps(25);
        chk("glitch_deb", sw_debounced, 10'h009);
        chk("glitch_strobes", W'(strobes[5]), 10'd0);

        // Bits 1 and 8 rise together, bit 8 falls back early.
        clear_strobes();
        sw_raw[1] = 1'b1;
        sw_raw[8] = 1'b1;
        steps(5);
        sw_raw[8] = 1'b0;
        wait_deb(10'h002, 10'h002, lat, chg_at, any_at);
        chk("simul_chg", chg_at, 10'h002);
        steps(20);
        chk("simul_deb", sw_debounced, 10'h00B);
        chk("simul_strobes8", W'(strobes[8]), 10'd0);

        // Async reset between edges while bit 2 is qualifying.
        sw_raw[2] = 1'b1;
        steps(8);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_deb", sw_debounced, 10'h000);
        chk("async_chg", sw_changed, 10'h000);
        chk("async_any", W'(sw_any_change), 10'h000);
        chk("async_tick", W'(tick), 10'h000);
        steps(3);
        rst = 1'b0;
        wait_deb(10'h00F, 10'h00F, lat, chg_at, any_at);
        chk_lat("async_relat", lat);
        chk("async_rechg", chg_at, 10'h00F);

        // Random toggling, checked every cycle by the model.
        for (int c = 0; c < 800; c++) begin
            if ((c / 100) % 2 == 0 && $urandom_range(0, 5) == 0)
                sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
            else if ((c / 100) % 2 == 1 && $urandom_range(0, 29) == 0)
                sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Conditions the 10 raw slide-switch pins from the board before they reach the Nios system's switches PIO input (switches_export).
- Each bit gets a 2-flop synchroniser and a per-bit stability counter, clocked by a shared prescaler tick.
- Outputs a clean debounced vector and one-cycle change strobes, which can later drive a PIO edge-capture IRQ or custom-instruction logic.

Parameters:
- WIDTH, 10, number of switch bits.
- TICK_DIV, 50000, clk_clk cycles per sample tick (1 ms at 50 MHz); legal range ≥2.
- STABLE_TICKS, 20, consecutive ticks a synchronised bit must differ from the current output before that output flips; legal range ≥1.

Ports:
- clk_clk  input  1  system clock, same domain as the Nios system.
- reset_reset  input  1  reset, asynchronous, active-high.
- sw_raw  input  WIDTH  raw asynchronous switch pins.
- sw_debounced  output  WIDTH  debounced level; drives switches_export.
- sw_changed  output  WIDTH  one-cycle per-bit strobe, asserted in the cycle sw_debounced bit flips.
- sw_any_change  output  1  OR of sw_changed.
- tick  output  1  prescaler strobe, exported for observability.

Behaviour:
- Reset (async assert, sync release by system): sync flops, sw_debounced, sw_changed, sw_any_change, tick, prescaler and all bit counters go to 0.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. sync2 lags sw_raw by 2 cycles. No other logic touches sw_raw.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick is registered high for exactly one cycle when the prescaler equals TICK_DIV-1. The first tick follows the TICK_DIV-th rising edge after reset release.
- Per-bit counter, width clog2(STABLE_TICKS+1), handled per bit i each cycle:
  - If sync2[i] == sw_debounced[i], counter is cleared, regardless of tick.
  - Otherwise, if tick and counter == STABLE_TICKS-1: sw_debounced[i] toggles, sw_changed[i]=1, counter cleared.
  - Otherwise, if tick: counter +1.
  - Otherwise: hold.
- Counter never exceeds STABLE_TICKS-1, so no wrap-around is possible.
- Bounce: any cycle where sync2[i] returns to the output value clears the counter. A glitch shorter than one tick period therefore never reaches a flip, provided STABLE_TICKS ≥ 2.
- sw_changed is registered. It is high in the same cycle sw_debounced shows the new value and deasserts the next cycle. sw_any_change is the registered OR of the next-state sw_changed, so it is cycle-aligned with sw_changed.
- Simultaneous events:
  - Bits are independent.
  - Several bits may flip on the same tick; sw_changed then shows multiple ones.
  - A bit whose sync2 reverts in the same cycle as a tick does not advance.
- Latency from a clean sw_raw step to the sw_debounced flip:
  - min 2+(STABLE_TICKS-1)*TICK_DIV+1 cycles
  - max 2+STABLE_TICKS*TICK_DIV+1 cycles
- Reset mid-count: everything clears. After release, the output is 0; if a switch is held high, it re-qualifies with full latency and then strobes sw_changed.

Decomposition:
- Package switch_debounce_pkg: default constants SW_WIDTH=10, SW_TICK_DIV=50000, SW_STABLE_TICKS=20, and a function computing counter width.
- One sub-module, debounce_bit: holds one bit's counter, output flop and change strobe. It takes sync2 bit and tick, and is instantiated WIDTH times via generate.
- Synchroniser and prescaler stay in the top level.

Test Plan (TICK_DIV=4, STABLE_TICKS=3 unless noted):
- Reset with sw_raw=10'h3FF held → all outputs 0 during reset. sw_debounced=10'h3FF arrives 11–15 cycles after release, together with a single sw_changed=10'h3FF pulse and sw_any_change=1 for one cycle.
- Clean step: sw_raw bit0 0→1 at cycle T → sw_debounced[0]=1 between T+11 and T+15; sw_changed[0] high for exactly 1 cycle; other bits unchanged.
- Bounce: toggle bit3 every 3 cycles for 40 cycles, then hold 1 → no flip during bouncing; flip 11–15 cycles after the final edge; exactly one strobe.
- Short glitch: bit5 high for 3 cycles then low → sw_debounced[5] stays 0 and no strobe.
- Simultaneous: bits 1 and 8 step 1 on the same cycle, bit 8 reverts after 5 cycles → only bit1 flips; sw_changed=10'h002.
- Async reset asserted mid-qualification, between clock edges → outputs go to 0 immediately without a clock; after release, counting restarts from 0 and full latency applies.
